// File: rtl/ioctl_upload_server_if.sv
// rtl/ioctl_upload_server_if.sv - ioctl upload handshake between hps_io and the upload server
interface ioctl_upload_server_if;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr,
    input  ioctl_din, ioctl_wait
  );

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr,
    output ioctl_din, ioctl_wait
  );
endinterface

// File: rtl/ioctl_upload_server.sv
// rtl/ioctl_upload_server.sv - Serves HPS upload reads of core memory through the ioctl channel
module ioctl_upload_server #(
  parameter int         AW          = 10,
  parameter int         SIZE        = 1024,
  parameter int         RAM_LAT     = 1,
  parameter logic [7:0] FILL        = 8'hFF,
  parameter int         ACK_TIMEOUT = 4095
) (
  input  logic                 clk_sys,
  input  logic                 Reset_I,
  ioctl_upload_server_if.slave ioctl,
  output logic                 pause_req,
  input  logic                 pause_ack,
  output logic [AW-1:0]        ram_addr,
  output logic                 ram_rd,
  input  logic [7:0]           ram_q,
  output logic                 upload_done,
  output logic                 timeout_flag,
  output logic [15:0]          byte_count
);

  localparam int              TW         = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [24:0]     SIZE_A     = 25'(SIZE);
  localparam logic [1:0]      LAT_INIT   = 2'(RAM_LAT);

  if (SIZE > (1 << AW)) begin : g_bad_size
    $error("ioctl_upload_server: SIZE exceeds the RAM address space");
  end
  if (RAM_LAT < 1 || RAM_LAT > 3) begin : g_bad_lat
    $error("ioctl_upload_server: RAM_LAT must be 1..3");
  end
  if (ACK_TIMEOUT < 1) begin : g_bad_timeout
    $error("ioctl_upload_server: ACK_TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_HALT, S_SERVE, S_FETCH, S_RELEASE} state_t;

  state_t          state, state_n;
  logic            upload_r, upload_d;
  logic [TW-1:0]   timer, timer_n;
  logic [1:0]      lat_cnt, lat_n;
  logic [7:0]      din_r, din_n;
  logic            wait_r, wait_n;
  logic            preq_n, rd_n, done_n, tflag_n, release_n;
  logic [AW-1:0]   addr_n;
  logic [15:0]     count_n, count_inc;

  assign ioctl.ioctl_din  = din_r;
  assign ioctl.ioctl_wait = wait_r;
  assign count_inc = (byte_count == 16'hFFFF) ? byte_count : byte_count + 16'd1;

  always_ff @(posedge clk_sys or negedge Reset_I) begin
    if (!Reset_I) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    lat_n     = lat_cnt;
    din_n     = din_r;
    wait_n    = wait_r;
    preq_n    = pause_req;
    addr_n    = ram_addr;
    rd_n      = 1'b0;
    done_n    = 1'b0;
    tflag_n   = timeout_flag;
    count_n   = byte_count;
    release_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (upload_r && !upload_d) begin
          state_n = S_HALT;
          preq_n  = 1'b1;
          wait_n  = 1'b1;
          count_n = 16'd0;
          tflag_n = 1'b0;
          timer_n = '0;
        end
      end
      S_HALT: begin
        if (!upload_r) begin
          release_n = 1'b1;
        end else if (pause_ack) begin
          state_n = S_SERVE;
          wait_n  = 1'b0;
        end else if (timer == TIMER_LAST) begin
          // Serve anyway so a core that never acknowledges cannot stall the HPS.
          state_n = S_SERVE;
          wait_n  = 1'b0;
          tflag_n = 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_SERVE: begin
        if (!upload_r) begin
          release_n = 1'b1;
        end else if (ioctl.ioctl_rd) begin
          if (ioctl.ioctl_addr < SIZE_A) begin
            addr_n  = ioctl.ioctl_addr[AW-1:0];
            rd_n    = 1'b1;
            wait_n  = 1'b1;
            lat_n   = LAT_INIT;
            state_n = S_FETCH;
          end else begin
            din_n   = FILL;
            count_n = count_inc;
          end
        end
      end
      S_FETCH: begin
        // Strobes arriving here are protocol violations and are dropped.
        if (!upload_r) begin
          release_n = 1'b1;
        end else if (lat_cnt == 2'd0) begin
          din_n   = ram_q;
          count_n = count_inc;
          wait_n  = 1'b0;
          state_n = S_SERVE;
        end else begin
          lat_n = lat_cnt - 2'd1;
        end
      end
      S_RELEASE: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (release_n) begin
      state_n = S_RELEASE;
      preq_n  = 1'b0;
      wait_n  = 1'b0;
      done_n  = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge Reset_I) begin
    if (!Reset_I) begin
      upload_r     <= 1'b0;
      upload_d     <= 1'b0;
      timer        <= '0;
      lat_cnt      <= 2'd0;
      din_r        <= 8'h00;
      wait_r       <= 1'b0;
      pause_req    <= 1'b0;
      ram_addr     <= '0;
      ram_rd       <= 1'b0;
      upload_done  <= 1'b0;
      timeout_flag <= 1'b0;
      byte_count   <= 16'd0;
    end else begin
      upload_r     <= ioctl.ioctl_upload;
      upload_d     <= upload_r;
      timer        <= timer_n;
      lat_cnt      <= lat_n;
      din_r        <= din_n;
      wait_r       <= wait_n;
      pause_req    <= preq_n;
      ram_addr     <= addr_n;
      ram_rd       <= rd_n;
      upload_done  <= done_n;
      timeout_flag <= tflag_n;
      byte_count   <= count_n;
    end
  end

endmodule
